// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, runs a req/ack handshake with
// instruction memory, latches the returned word and presents its decoded
// fields to the controller and datapath.
// Optional feature: define IFETCH_PERF_CNT_EN to add the fetch_cnt and
// stall_cnt performance counter outputs.
module ifetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              flush_valid,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [15:0]       imm16,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] tgt;
  logic              retire;

  // The PC is never changed while a request is outstanding (DRAIN parks the
  // new target in tgt instead), so the fetch address is simply the PC.
  assign imem_addr = pc;
  assign pc_plus4  = pc + ADDR_W'(4);
  assign retire    = instr_valid && !stall;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];

  // Fetch FSM with registered request/valid outputs and PC/target tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      tgt         <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush_valid) begin
            pc <= flush_pc;
          end
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end

        S_FETCH: begin
          if (flush_valid) begin
            if (imem_ack) begin
              // Handshake completed this cycle: drop the word and refetch.
              pc <= flush_pc;
            end else begin
              // Request still outstanding: keep address stable, park target.
              tgt   <= flush_pc;
              state <= S_DRAIN;
            end
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_VALID;
          end
        end

        S_VALID: begin
          if (flush_valid) begin
            pc          <= flush_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_FETCH;
          end else if (!stall) begin
            pc          <= redirect_valid ? redirect_pc : pc_plus4;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_FETCH;
          end
        end

        S_DRAIN: begin
          if (imem_ack) begin
            // A flush arriving together with the ack is the last one and wins.
            pc    <= flush_valid ? flush_pc : tgt;
            state <= S_FETCH;
          end else if (flush_valid) begin
            tgt <= flush_pc;
          end
        end

        default: begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Free-running performance counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (retire) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (instr_valid && stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed table-driven bench for ifetch_unit plus a hand-written reset sequence.
module tb_ifetch_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush_valid;
  logic [ADDR_W-1:0] flush_pc;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm16;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]       fetch_cnt;
  logic [31:0]       stall_cnt;
`endif

  ifetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .opcode         (opcode),
    .funct          (funct),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .shamt          (shamt),
    .imm16          (imm16),
    .pc             (pc),
    .pc_plus4       (pc_plus4)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        stl;
    logic        rv;
    logic [31:0] rpc;
    logic        fv;
    logic [31:0] fpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs [0:63];
  int unsigned n_vec;
  int unsigned n_cmp;
  int unsigned n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic ack, input logic [31:0] rdata, input logic stl,
                   input logic rv, input logic [31:0] rpc,
                   input logic fv, input logic [31:0] fpc,
                   input logic e_req, input logic [31:0] e_addr,
                   input logic e_valid, input logic [31:0] e_instr);
    vecs[n_vec] = {ack, rdata, stl, rv, rpc, fv, fpc, e_req, e_addr, e_valid, e_instr};
    n_vec++;
  endtask

  task automatic drive_idle();
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    flush_valid    = 1'b0;
    flush_pc       = 32'h0;
  endtask

  initial begin
    n_vec = 0;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive_idle();

    //  ack rdata         stl rv rpc           fv fpc          req addr          vld instr
    v(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,      0, 32'h0,         0, 32'h0);        // IDLE
    v(1, 32'h8C010004,  0, 0, 32'h0,        0, 32'h0,      1, 32'h0,         0, 32'h0);        // FETCH @0, zero-wait ack
    v(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,      0, 32'h0,         1, 32'h8C010004); // VALID, retire
    v(1, 32'h00221820,  0, 0, 32'h0,        0, 32'h0,      1, 32'h4,         0, 32'h8C010004); // FETCH @4
    v(0, 32'h0,         1, 1, 32'h200,      0, 32'h0,      0, 32'h4,         1, 32'h00221820); // stall + redirect ignored
    v(0, 32'h0,         1, 1, 32'h200,      0, 32'h0,      0, 32'h4,         1, 32'h00221820);
    v(0, 32'h0,         1, 1, 32'h200,      0, 32'h0,      0, 32'h4,         1, 32'h00221820);
    v(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,      0, 32'h4,         1, 32'h00221820); // retire sequential
    v(1, 32'h10000003,  0, 0, 32'h0,        0, 32'h0,      1, 32'h8,         0, 32'h00221820); // FETCH @8
    v(0, 32'h0,         0, 1, 32'h100,      0, 32'h0,      0, 32'h8,         1, 32'h10000003); // retire with redirect
    v(0, 32'h0,         0, 0, 32'h0,        1, 32'h80,     1, 32'h100,       0, 32'h10000003); // FETCH @100, flush no ack
    v(0, 32'h0,         0, 0, 32'h0,        1, 32'h90,     1, 32'h100,       0, 32'h10000003); // DRAIN, second flush
    v(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,      1, 32'h100,       0, 32'h10000003); // DRAIN
    v(1, 32'hDEADBEEF,  0, 0, 32'h0,        0, 32'h0,      1, 32'h100,       0, 32'h10000003); // DRAIN ack, discarded
    v(1, 32'h20020005,  0, 0, 32'h0,        0, 32'h0,      1, 32'h90,        0, 32'h10000003); // FETCH @90
    v(0, 32'h0,         0, 1, 32'hFFFFFFFC, 0, 32'h0,      0, 32'h90,        1, 32'h20020005); // redirect to top
    v(1, 32'h00000000,  0, 0, 32'h0,        0, 32'h0,      1, 32'hFFFFFFFC,  0, 32'h20020005); // FETCH @FFFFFFFC
    v(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,      0, 32'hFFFFFFFC,  1, 32'h00000000); // retire, wraps
    v(1, 32'h8C010004,  0, 0, 32'h0,        0, 32'h0,      1, 32'h0,         0, 32'h00000000); // FETCH @0
    v(0, 32'h0,         0, 1, 32'h300,      1, 32'h40,     0, 32'h0,         1, 32'h8C010004); // flush beats redirect
    v(1, 32'hCAFEF00D,  0, 0, 32'h0,        1, 32'h50,     1, 32'h40,        0, 32'h8C010004); // flush with ack
    v(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,      1, 32'h50,        0, 32'h8C010004); // FETCH @50 waiting
    v(1, 32'h03E00008,  0, 0, 32'h0,        0, 32'h0,      1, 32'h50,        0, 32'h8C010004);
    v(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,      0, 32'h50,        1, 32'h03E00008); // retire
    v(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,      1, 32'h54,        0, 32'h03E00008); // FETCH @54, ack withheld

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    #1;
    check("rst.req",      {31'h0, imem_req},    32'h0);
    check("rst.valid",    {31'h0, instr_valid}, 32'h0);
    check("rst.pc",       pc,                   32'h0);
    check("rst.pc_plus4", pc_plus4,             32'h4);
    check("rst.instr",    instr,                32'h0);
    check("rst.opcode",   {26'h0, opcode},      32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < int'(n_vec); i++) begin
      imem_ack       = vecs[i].ack;
      imem_rdata     = vecs[i].rdata;
      stall          = vecs[i].stl;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      flush_valid    = vecs[i].fv;
      flush_pc       = vecs[i].fpc;
      #1;
      check($sformatf("v%0d.req", i),    {31'h0, imem_req},    {31'h0, vecs[i].e_req});
      check($sformatf("v%0d.addr", i),   imem_addr,            vecs[i].e_addr);
      check($sformatf("v%0d.pc", i),     pc,                   vecs[i].e_addr);
      check($sformatf("v%0d.valid", i),  {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("v%0d.instr", i),  instr,                vecs[i].e_instr);
      check($sformatf("v%0d.fields", i), {opcode, rs, rt, rd, shamt, funct}, vecs[i].e_instr);
      check($sformatf("v%0d.imm16", i),  {16'h0, imm16},       {16'h0, vecs[i].e_instr[15:0]});
      check($sformatf("v%0d.pc_plus4", i), pc_plus4,           vecs[i].e_addr + 32'd4);
      if (i == 2) begin
        check("v2.opcode_lw", {26'h0, opcode}, 32'h23);
      end
      if (i == 4) begin
        check("v4.opcode_r", {26'h0, opcode}, 32'h00);
        check("v4.funct_add", {26'h0, funct}, 32'h20);
      end
      if (i == 17) begin
        check("v17.pc_plus4_wrap", pc_plus4, 32'h0);
      end
      @(negedge clk);
    end

`ifdef IFETCH_PERF_CNT_EN
    check("perf.stall_cnt", stall_cnt, 32'd3);
`endif

    // Reset asserted mid-FETCH; the late ack must never produce an instruction.
    drive_idle();
    rst = 1'b1;
    #1;
    check("midrst.req",   {31'h0, imem_req},    32'h0);
    check("midrst.valid", {31'h0, instr_valid}, 32'h0);
    check("midrst.pc",    pc,                   32'h0);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C010004;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post.idle_req",   {31'h0, imem_req},    32'h0);
    check("post.idle_valid", {31'h0, instr_valid}, 32'h0);
    check("post.idle_instr", instr,                32'h0);
`ifdef IFETCH_PERF_CNT_EN
    check("post.fetch_cnt", fetch_cnt, 32'h0);
    check("post.stall_cnt", stall_cnt, 32'h0);
`endif
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    check("post.fetch_req",   {31'h0, imem_req},    32'h1);
    check("post.fetch_addr",  imem_addr,            32'h0);
    check("post.fetch_valid", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    #1;
    check("post.still_req",   {31'h0, imem_req},    32'h1);
    check("post.still_valid", {31'h0, instr_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the main controller.
- Holds the PC and runs a req/ack handshake with instruction memory. Latches the returned word and presents the decoded fields (opcode, funct, registers, immediate) to the controller and datapath.
- Advances on consume, or jumps to a branch/jump target or a flush target.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request, held until imem_ack.
- imem_addr  output  ADDR_W  fetch address, stable while imem_req=1.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- stall  input  1  consumer not ready; held instruction must not retire.
- redirect_valid  input  1  branch/jump taken by the instruction retiring this cycle.
- redirect_pc  input  ADDR_W  branch/jump target.
- flush_valid  input  1  unconditional restart (exception/debug); any state.
- flush_pc  input  ADDR_W  flush target.
- instr_valid  output  1  instr and decoded fields are valid.
- instr  output  32  held instruction word.
- opcode  output  6  instr[31:26].
- funct  output  6  instr[5:0].
- rs, rt, rd  output  5 each  instr[25:21], [20:16], [15:11].
- shamt  output  5  instr[10:6].
- imm16  output  16  instr[15:0].
- pc  output  ADDR_W  address of held instruction.
- pc_plus4  output  ADDR_W  pc+4, modulo 2^ADDR_W.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, pc=RESET_PC, instr=32'h0 (NOP), instr_valid=0, imem_req=0.
  - All decoded fields are 0; pc_plus4=RESET_PC+4.
- States:
  - IDLE: entered from reset. Next cycle goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack: instr<=imem_rdata, go to VALID.
  - VALID: instr_valid=1, imem_req=0.
    - Retire when instr_valid && !stall.
    - On retire: pc<=redirect_pc if redirect_valid, else pc+4. Go to FETCH.
    - With stall=1: hold all outputs; redirect_valid is ignored.
  - DRAIN: imem_req=1, imem_addr=old address (held stable).
    - Waits for the outstanding ack and discards the data.
    - Then goes to FETCH at the stored target.
- Output decode: imem_req=1 in FETCH and DRAIN only. instr_valid=1 in VALID only.
- Flush rules (flush overrides redirect and sequential advance):
  - IDLE or VALID: pc<=flush_pc, go to FETCH. instr_valid drops the next cycle.
  - FETCH with imem_ack=1 the same cycle: data discarded, pc<=flush_pc, go to FETCH.
  - FETCH without ack: tgt<=flush_pc, go to DRAIN. imem_addr keeps the old pc until ack.
  - DRAIN: tgt<=flush_pc (last flush wins), stay in DRAIN.
  - On DRAIN exit: pc<=tgt.
- Latency:
  - Ack in cycle N -> instr_valid=1 in cycle N+1.
  - Retire in cycle M -> imem_req=1 with the new address in cycle M+1.
  - Minimum 2 cycles per instruction with a zero-wait memory (ack in the same cycle as req).
- Arithmetic: pc+4 wraps modulo 2^ADDR_W. The low 2 bits of targets pass through unchecked.
- Reset mid-operation: immediate return to reset values. Any outstanding memory ack after release is ignored, because IDLE does not sample imem_ack.
- The decoded fields are pure wiring from the instr register (no extra latency).

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports fetch_cnt (32) and stall_cnt (32), both reset to 0.
  - fetch_cnt increments on every retire.
  - stall_cnt increments each cycle with instr_valid && stall.
  - Both wrap at 2^32; neither is cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory acks the same cycle as req with words 0x8C010004, 0x00221820, stall=0:
  - imem_addr sequence 0x0, 0x4.
  - instr_valid pulses, opcode 0x23 then 0x00 with funct 0x20.
  - Exactly 2 cycles per instruction.
- Instruction held with stall=1 for 3 cycles, redirect_valid=1 during the stall:
  - Outputs frozen, redirect ignored.
  - After stall drops with redirect_valid=0, the next address is pc+4.
- Retire with redirect_valid=1, redirect_pc=0x100 -> next imem_addr=0x100, later pc=0x100.
- flush_valid=1, flush_pc=0x80 in FETCH while ack is delayed 3 cycles:
  - imem_addr stays at the old pc until ack; the returned word is never presented.
  - Next req at 0x80.
  - A second flush to 0x90 during DRAIN -> next req at 0x90.
- pc=0xFFFF_FFFC retires sequentially -> next imem_addr=0x0000_0000.
- Assert rst during FETCH with a later ack -> no instr_valid.
  - After release: IDLE, then req at RESET_PC.
  - With IFETCH_PERF_CNT_EN: both counters read 0.
